div_nr_param: RTL and testbench
===============================

DIV_NR_PARAM -- requirements
Module: div_nr_param

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning operand, quotient and remainder width; legal values 4..64.
REQ-002 SHALL have parameter CNT_W, default $clog2(WIDTH+1), meaning iteration counter width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port start  input  1  request to begin a division; sampled on clk.
REQ-006 SHALL have port signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; captured with start.
REQ-007 SHALL have port dividend  input  WIDTH  numerator; captured with start.
REQ-008 SHALL have port divisor  input  WIDTH  denominator; captured with start.
REQ-009 SHALL have port busy  output  1  high while a division is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse; results valid.
REQ-011 SHALL have port quotient  output  WIDTH  result, held until the next accepted start.
REQ-012 SHALL have port remainder  output  WIDTH  residue, held until the next accepted start.
REQ-013 SHALL have port div_by_zero  output  1  flag, valid with done, held with the results.
REQ-014 SHALL have port overflow  output  1  signed MIN/-1 flag, valid with done, held with the results.

Function
REQ-015 SHALL implement an FSM with states IDLE, RUN, FIX and DONE.
REQ-016 SHALL accept start only in IDLE or DONE; start in RUN or FIX SHALL be ignored.
REQ-017 On accepted start SHALL register the operands and mode, take magnitudes when signed_mode=1, clear the counter and enter RUN; busy SHALL rise the next cycle.
REQ-018 RUN SHALL perform one non-restoring step per cycle (shift {A,Q} left 1; subtract |divisor| if A>=0, else add; Q[0] = ~A_new[MSB]) for exactly WIDTH cycles.
REQ-019 A SHALL be WIDTH+1 bits wide to hold the sign of the partial remainder.
REQ-020 FIX SHALL restore a negative A by adding |divisor|, then apply signs: quotient negated if the operand signs differ, remainder takes the dividend's sign (truncation toward zero).
REQ-021 done SHALL pulse in the cycle after FIX, i.e. exactly WIDTH+2 cycles after the accepting edge; busy SHALL fall in that same cycle.
REQ-022 After the done pulse, state SHALL be DONE/IDLE with results held; back-to-back start in the done cycle SHALL be accepted.
REQ-023 A divisor of 0 SHALL skip RUN: done pulses 2 cycles after accept with quotient = all ones, remainder = dividend, div_by_zero=1.
REQ-024 Signed dividend = 2^(WIDTH-1) with divisor = -1 SHALL give quotient = 2^(WIDTH-1), remainder = 0, overflow=1, with normal latency.
REQ-025 div_by_zero and overflow SHALL clear on the next accepted start.
REQ-026 Unsigned mode SHALL never assert overflow.

Reset
REQ-027 rst SHALL force IDLE and drive busy, done, quotient, remainder, div_by_zero and overflow to 0 at the next edge.
REQ-028 rst asserted mid-division SHALL abort the operation with no done pulse; rst SHALL have priority over start.

Structure
REQ-029 State enum, WIDTH default and the divide-by-zero quotient constant SHALL reside in shared package div_pkg.
REQ-030 Sign negation/correction SHALL be a separate combinational sub-module div_sign_fix, parametrised by WIDTH.

Verification
REQ-031 WIDTH=16, signed, 100/7 -> done at accept+18, quotient=14, remainder=2, flags 0.
REQ-032 Signed -100/7 -> quotient=0xFFF2, remainder=0xFFFE; and 100/-7 -> quotient=0xFFF2, remainder=2.
REQ-033 Unsigned 0xFFFF/2 -> quotient=0x7FFF, remainder=1, overflow=0.
REQ-034 Signed 0x8000/0xFFFF -> quotient=0x8000, remainder=0, overflow=1; then 5/0 -> done at accept+2, quotient=0xFFFF, remainder=5, div_by_zero=1, overflow=0.
REQ-035 start, rst at cycle 8, start again at cycle 10 -> no done from the first operation; second result correct at its accept+18; start pulsed during RUN ignored.
REQ-036 Random signed/unsigned sweep at WIDTH=8 and WIDTH=32 against a reference model -> zero mismatches.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the non-restoring divider: FSM encoding, default
// operand width and the quotient reported on divide-by-zero.
package div_pkg;

  localparam int DIV_WIDTH_DEF = 16;

  // Sliced down to WIDTH bits by the divider; all ones at every legal width.
  localparam logic [63:0] DIV_ZERO_QUOT = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } div_state_t;

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negation of a value pair. Used both to take
// operand magnitudes and to apply result signs after the unsigned core.
module div_sign_fix #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_neg_a,
  input  logic             i_neg_b,
  output logic [WIDTH-1:0] o_a,
  output logic [WIDTH-1:0] o_b
);

  assign o_a = i_neg_a ? (~i_a + 1'b1) : i_a;
  assign o_b = i_neg_b ? (~i_b + 1'b1) : i_b;

endmodule

// File: rtl/div_nr_param.sv
// Multi-cycle non-restoring divider, signed or unsigned, one quotient bit per
// clock, truncating toward zero.
//
// state   | meaning
// IDLE    | waiting for start, results held
// RUN     | one non-restoring step per cycle, WIDTH cycles
// FIX     | restore negative remainder, apply signs, load outputs
// DONE    | done pulse; start here is accepted back-to-back
module div_nr_param
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEF,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_t       r_state;
  logic [WIDTH:0]   r_a;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_m;
  logic [WIDTH-1:0] r_dividend;
  logic [CNT_W-1:0] r_cnt;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_dvz_pend;
  logic             r_ovf_pend;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic             r_dvz;
  logic             r_ovf;

  logic             w_accept;
  logic             w_neg_dd;
  logic             w_neg_dv;
  logic [WIDTH-1:0] w_abs_dd;
  logic [WIDTH-1:0] w_abs_dv;
  logic [WIDTH:0]   w_a_sh;
  logic [WIDTH:0]   w_a_step;
  logic [WIDTH:0]   w_a_restored;
  logic [WIDTH-1:0] w_fix_q;
  logic [WIDTH-1:0] w_fix_r;

  assign w_accept = start && (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_neg_dd = signed_mode && dividend[WIDTH-1];
  assign w_neg_dv = signed_mode && divisor[WIDTH-1];

  // Magnitude of MIN wraps to MIN, which is the correct unsigned magnitude.
  div_sign_fix #(.WIDTH(WIDTH)) u_abs (
    .i_a     (dividend),
    .i_b     (divisor),
    .i_neg_a (w_neg_dd),
    .i_neg_b (w_neg_dv),
    .o_a     (w_abs_dd),
    .o_b     (w_abs_dv)
  );

  // Shifted value may wrap mod 2^(WIDTH+1); the post-add/sub result fits.
  assign w_a_sh       = {r_a[WIDTH-1:0], r_q[WIDTH-1]};
  assign w_a_step     = r_a[WIDTH] ? (w_a_sh + {1'b0, r_m}) : (w_a_sh - {1'b0, r_m});
  assign w_a_restored = r_a[WIDTH] ? (r_a + {1'b0, r_m}) : r_a;

  div_sign_fix #(.WIDTH(WIDTH)) u_fix (
    .i_a     (r_q),
    .i_b     (w_a_restored[WIDTH-1:0]),
    .i_neg_a (r_neg_q),
    .i_neg_b (r_neg_r),
    .o_a     (w_fix_q),
    .o_b     (w_fix_r)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_a        <= '0;
      r_q        <= '0;
      r_m        <= '0;
      r_dividend <= '0;
      r_cnt      <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_dvz_pend <= 1'b0;
      r_ovf_pend <= 1'b0;
      r_quot     <= '0;
      r_rem      <= '0;
      r_dvz      <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_accept) begin
            r_a        <= '0;
            r_q        <= w_abs_dd;
            r_m        <= w_abs_dv;
            r_dividend <= dividend;
            r_cnt      <= '0;
            r_neg_q    <= w_neg_dd ^ w_neg_dv;
            r_neg_r    <= w_neg_dd;
            r_dvz_pend <= (divisor == '0);
            r_ovf_pend <= signed_mode && (dividend == MIN_VAL) && (divisor == '1);
            r_dvz      <= 1'b0;
            r_ovf      <= 1'b0;
            r_state    <= (divisor == '0) ? ST_FIX : ST_RUN;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          r_a   <= w_a_step;
          r_q   <= {r_q[WIDTH-2:0], ~w_a_step[WIDTH]};
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(WIDTH - 1)) r_state <= ST_FIX;
        end
        ST_FIX: begin
          if (r_dvz_pend) begin
            r_quot <= DIV_ZERO_QUOT[WIDTH-1:0];
            r_rem  <= r_dividend;
          end else begin
            r_quot <= w_fix_q;
            r_rem  <= w_fix_r;
          end
          r_dvz   <= r_dvz_pend;
          r_ovf   <= r_ovf_pend;
          r_state <= ST_DONE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy        = (r_state == ST_RUN) || (r_state == ST_FIX);
  assign done        = (r_state == ST_DONE);
  assign quotient    = r_quot;
  assign remainder   = r_rem;
  assign div_by_zero = r_dvz;
  assign overflow    = r_ovf;

endmodule

// File: tb/tb_div_nr_param.sv
// Bench for div_nr_param: directed cases at WIDTH=16 plus random sweeps at
// WIDTH=8 and WIDTH=32 against an arithmetic reference model.
module tb_div_nr_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        go;
  logic        sm;
  logic [63:0] b_dd;
  logic [63:0] b_dv;
  int          cur_sel;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  logic        s16, s8, s32;
  logic        busy16, done16, dz16, ov16;
  logic        busy8, done8, dz8, ov8;
  logic        busy32, done32, dz32, ov32;
  logic [15:0] q16, r16;
  logic [7:0]  q8, r8;
  logic [31:0] q32, r32;

  assign s16 = go && (cur_sel == 0);
  assign s8  = go && (cur_sel == 1);
  assign s32 = go && (cur_sel == 2);

  div_nr_param #(.WIDTH(16)) u_d16 (
    .clk(clk), .rst(rst), .start(s16), .signed_mode(sm),
    .dividend(b_dd[15:0]), .divisor(b_dv[15:0]),
    .busy(busy16), .done(done16), .quotient(q16), .remainder(r16),
    .div_by_zero(dz16), .overflow(ov16));

  div_nr_param #(.WIDTH(8)) u_d8 (
    .clk(clk), .rst(rst), .start(s8), .signed_mode(sm),
    .dividend(b_dd[7:0]), .divisor(b_dv[7:0]),
    .busy(busy8), .done(done8), .quotient(q8), .remainder(r8),
    .div_by_zero(dz8), .overflow(ov8));

  div_nr_param #(.WIDTH(32)) u_d32 (
    .clk(clk), .rst(rst), .start(s32), .signed_mode(sm),
    .dividend(b_dd[31:0]), .divisor(b_dv[31:0]),
    .busy(busy32), .done(done32), .quotient(q32), .remainder(r32),
    .div_by_zero(dz32), .overflow(ov32));

  logic        o_busy, o_done, o_dz, o_ov;
  logic [63:0] o_q, o_r;

  always_comb begin
    o_busy = busy16; o_done = done16; o_dz = dz16; o_ov = ov16;
    o_q = {48'd0, q16}; o_r = {48'd0, r16};
    if (cur_sel == 1) begin
      o_busy = busy8; o_done = done8; o_dz = dz8; o_ov = ov8;
      o_q = {56'd0, q8}; o_r = {56'd0, r8};
    end else if (cur_sel == 2) begin
      o_busy = busy32; o_done = done32; o_dz = dz32; o_ov = ov32;
      o_q = {32'd0, q32}; o_r = {32'd0, r32};
    end
  end

  function automatic int width_of(input int sel);
    return (sel == 1) ? 8 : (sel == 2) ? 32 : 16;
  endfunction

  function automatic logic [63:0] mask_of(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  // Reference: plain integer division truncating toward zero.
  task automatic ref_div(input int w, input bit smode, input logic [63:0] dd,
                         input logic [63:0] dv, output logic [63:0] q,
                         output logic [63:0] r, output bit dz, output bit ov);
    logic [63:0] m;
    longint sa, sb;
    m  = mask_of(w);
    dz = 1'b0;
    ov = 1'b0;
    if ((dv & m) == 64'd0) begin
      q  = m;
      r  = dd & m;
      dz = 1'b1;
    end else if (smode) begin
      sa = $signed(dd << (64 - w)) >>> (64 - w);
      sb = $signed(dv << (64 - w)) >>> (64 - w);
      q  = 64'(sa / sb) & m;
      r  = 64'(sa % sb) & m;
      ov = (sa == -(longint'(1) <<< (w - 1))) && (sb == -1);
    end else begin
      q = ((dd & m) / (dv & m)) & m;
      r = ((dd & m) % (dv & m)) & m;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issues one division from a negedge and returns at the negedge of the
  // done cycle (or when the cycle budget runs out).
  task automatic run_op(input int sel, input bit smode, input logic [63:0] dd,
                        input logic [63:0] dv, input int poke, input string tag);
    int w, cyc, lat;
    logic [63:0] eq, er;
    bit edz, eov;
    w = width_of(sel);
    ref_div(w, smode, dd, dv, eq, er, edz, eov);
    lat = edz ? 2 : w + 2;
    cur_sel = sel;
    sm   = smode;
    b_dd = dd;
    b_dv = dv;
    go   = 1'b1;
    cyc  = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        go = 1'b0;
        chk({tag, " busy_rise"}, {63'd0, o_busy}, 64'd1);
        chk({tag, " flags_clear"}, {62'd0, o_dz, o_ov}, 64'd0);
      end
      if (poke > 1 && cyc == poke) begin
        go   = 1'b1;
        b_dd = 64'($urandom);
        b_dv = 64'd1;
      end
      if (poke > 1 && cyc == poke + 1) go = 1'b0;
    end while (!o_done && cyc < w + 10);
    chk({tag, " latency"}, 64'(cyc), 64'(lat));
    chk({tag, " busy_fall"}, {63'd0, o_busy}, 64'd0);
    chk({tag, " quotient"}, o_q, eq);
    chk({tag, " remainder"}, o_r, er);
    chk({tag, " dvz"}, {63'd0, o_dz}, {63'd0, edz});
    chk({tag, " ovf"}, {63'd0, o_ov}, {63'd0, eov});
  endtask

  task automatic rand_op(input int sel, input string tag);
    int w, kind;
    logic [63:0] m, dd, dv;
    bit smode;
    w     = width_of(sel);
    m     = mask_of(w);
    smode = 1'($urandom_range(0, 1));
    kind  = $urandom_range(0, 9);
    dd    = {32'($urandom), 32'($urandom)} & m;
    dv    = {32'($urandom), 32'($urandom)} & m;
    if (kind == 0) dv = 64'd0;
    else if (kind == 1) begin dd = 64'd1 << (w - 1); dv = m; end
    else if (kind == 2) dv = 64'($urandom_range(1, 9));
    else if (kind == 3) dv = m;
    run_op(sel, smode, dd, dv, 0, tag);
  endtask

  initial begin
    bit seen_done;
    rst = 1'b1; go = 1'b0; sm = 1'b0; b_dd = '0; b_dv = '0; cur_sel = 0;
    repeat (3) @(negedge clk);
    chk("rst busy", {63'd0, o_busy}, 64'd0);
    chk("rst done", {63'd0, o_done}, 64'd0);
    chk("rst quotient", o_q, 64'd0);
    chk("rst remainder", o_r, 64'd0);
    chk("rst dvz", {63'd0, o_dz}, 64'd0);
    chk("rst ovf", {63'd0, o_ov}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op(0, 1'b1, 64'd100, 64'd7, 0, "s100/7");
    chk("s100/7 q_const", o_q, 64'd14);
    chk("s100/7 r_const", o_r, 64'd2);
    @(negedge clk);
    chk("done one-cycle", {63'd0, o_done}, 64'd0);
    chk("held quotient", o_q, 64'd14);

    run_op(0, 1'b1, 64'hFF9C, 64'd7, 0, "s-100/7");
    chk("s-100/7 q_const", o_q, 64'hFFF2);
    chk("s-100/7 r_const", o_r, 64'hFFFE);
    run_op(0, 1'b1, 64'd100, 64'hFFF9, 0, "s100/-7");
    chk("s100/-7 r_const", o_r, 64'd2);
    run_op(0, 1'b0, 64'hFFFF, 64'd2, 0, "uFFFF/2");
    chk("uFFFF/2 q_const", o_q, 64'h7FFF);
    run_op(0, 1'b1, 64'h8000, 64'hFFFF, 0, "sMIN/-1");
    chk("sMIN/-1 ovf_const", {63'd0, o_ov}, 64'd1);
    run_op(0, 1'b1, 64'd5, 64'd0, 0, "s5/0");
    chk("s5/0 q_const", o_q, 64'hFFFF);
    run_op(0, 1'b0, 64'h8000, 64'hFFFF, 0, "u8000/FFFF");
    run_op(0, 1'b1, 64'd1000, 64'd3, 5, "start_in_run");
    run_op(0, 1'b1, 64'd1000, 64'd3, 17, "start_in_fix");

    // Abort mid-division; rst coincides with a start request.
    @(negedge clk);
    cur_sel = 0; sm = 1'b1; b_dd = 64'd1000; b_dv = 64'd3; go = 1'b1;
    seen_done = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c == 1) go = 1'b0;
      if (c <= 8) seen_done |= o_done;
      if (c == 8) begin rst = 1'b1; go = 1'b1; end
    end
    chk("abort no_done", {63'd0, seen_done}, 64'd0);
    chk("abort busy", {63'd0, o_busy}, 64'd0);
    chk("abort done", {63'd0, o_done}, 64'd0);
    chk("abort quotient", o_q, 64'd0);
    chk("abort remainder", o_r, 64'd0);
    rst = 1'b0; go = 1'b0;
    @(negedge clk);
    run_op(0, 1'b1, 64'hFB2E, 64'd56, 0, "after_abort");

    for (int i = 0; i < 40; i++) rand_op(1, "rand8");
    for (int i = 0; i < 40; i++) rand_op(2, "rand32");
    for (int i = 0; i < 10; i++) rand_op(0, "rand16");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
